// File: rtl/pic_pkg.sv
// Shared definitions for the PIC command-write path.
// Contents:
//   pic_state_t     - initialization sequence state
//   *_BIT constants - bit positions of the command bytes' decode fields
//   STB_*           - bit index of each strobe inside the strobe vector
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } pic_state_t;

  localparam int ICW1_SEL_BIT = 4;
  localparam int LTIM_BIT     = 3;
  localparam int SNGL_BIT     = 1;
  localparam int IC4_BIT      = 0;
  localparam int OCW3_SEL_BIT = 3;

  localparam int STB_ICW1 = 0;
  localparam int STB_ICW2 = 1;
  localparam int STB_ICW3 = 2;
  localparam int STB_ICW4 = 3;
  localparam int STB_OCW1 = 4;
  localparam int STB_OCW2 = 5;
  localparam int STB_OCW3 = 6;
  localparam int NUM_STB  = 7;

endpackage

// File: rtl/pic_wr_sync.sv
// CPU write capture for the PIC: synchronizes cs_n/wr_n into the clk domain,
// keeps sampling a0/data while a write is active and fires one event on the
// trailing (rising) edge of wr_n.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   cs_n, wr_n        - asynchronous chip select / write strobe (active low)
//   a0, data_bus      - CPU address bit and write data
//   wr_event          - single-cycle pulse, a completed write is held
//   ev_a0, ev_data    - a0 and data captured for the write
module pic_wr_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] data_bus,
  output logic       wr_event,
  output logic       ev_a0,
  output logic [7:0] ev_data
);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic                   cs_s;
  logic                   wr_s;
  logic                   wr_d;
  logic                   armed;
  logic                   hold_sel;
  logic                   hold_a0;
  logic [7:0]             hold_data;

  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign wr_s = wr_sync[SYNC_STAGES-1];

  assign wr_event = hold_sel && !wr_d && wr_s;
  assign ev_a0    = hold_a0;
  assign ev_data  = hold_data;

  // armed only rises once wr_n has been seen high after reset, so a write
  // whose falling edge happened before reset release is never captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= '0;
      wr_sync   <= '0;
      wr_d      <= 1'b0;
      armed     <= 1'b0;
      hold_sel  <= 1'b0;
      hold_a0   <= 1'b0;
      hold_data <= '0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], wr_n};
      wr_d    <= wr_s;
      if (wr_s) begin
        armed <= 1'b1;
      end
      if (armed && !wr_s && !cs_s) begin
        hold_data <= data_bus;
        hold_a0   <= a0;
        hold_sel  <= 1'b1;
      end else if (wr_event) begin
        hold_sel <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pic_cmd_sequencer.sv
// Command-write sequencer for an 8259A-compatible PIC. Decodes CPU writes into
// ICW1-ICW4 / OCW1-OCW3, emits one-cycle strobes with a registered copy of the
// command byte, and keeps the ICW-derived configuration.
// Optional build macro: PIC_WR_ERR_EN adds the sticky wr_err output.
// Ports:
//   clk, reset                     - clock, asynchronous active-high reset
//   cs_n, wr_n, a0, data_bus       - CPU write interface
//   internal_bus                   - command byte of the last accepted write
//   icw1..4_write, ocw1..3_write   - one-cycle command strobes
//   init_done                      - ICW sequence complete
//   ltim, single_mode              - ICW1 D3, D1
//   vector_base                    - ICW2 D7:D3
//   cascade_cfg                    - ICW3 byte
//   auto_eoi, upm                  - ICW4 D1, D0
//   wr_err (PIC_WR_ERR_EN only)    - sticky flag for ignored writes
module pic_cmd_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] data_bus,
  output logic [7:0] internal_bus,
  output logic       icw1_write,
  output logic       icw2_write,
  output logic       icw3_write,
  output logic       icw4_write,
  output logic       ocw1_write,
  output logic       ocw2_write,
  output logic       ocw3_write,
  output logic       init_done,
  output logic       ltim,
  output logic       single_mode,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_cfg,
  output logic       auto_eoi,
  output logic       upm
`ifdef PIC_WR_ERR_EN
  ,
  output logic       wr_err
`endif
);

  logic               wr_event;
  logic               ev_a0;
  logic [7:0]         ev_data;
  pic_state_t         state;
  pic_state_t         state_nxt;
  logic [NUM_STB-1:0] stb_q;
  logic [NUM_STB-1:0] stb_nxt;
  logic               ic4;

  pic_wr_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_wr_sync (
    .clk      (clk),
    .reset    (reset),
    .cs_n     (cs_n),
    .wr_n     (wr_n),
    .a0       (a0),
    .data_bus (data_bus),
    .wr_event (wr_event),
    .ev_a0    (ev_a0),
    .ev_data  (ev_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= UNINIT;
    end else begin
      state <= state_nxt;
    end
  end

  // ICW1 wins from any state; everything else depends on where we are in the
  // sequence. A write that selects no strobe is ignored.
  always_comb begin
    state_nxt = state;
    stb_nxt   = '0;
    if (wr_event) begin
      if (!ev_a0 && ev_data[ICW1_SEL_BIT]) begin
        stb_nxt[STB_ICW1] = 1'b1;
        state_nxt         = WAIT_ICW2;
      end else begin
        case (state)
          WAIT_ICW2: begin
            if (ev_a0) begin
              stb_nxt[STB_ICW2] = 1'b1;
              if (!single_mode) state_nxt = WAIT_ICW3;
              else if (ic4)     state_nxt = WAIT_ICW4;
              else              state_nxt = READY;
            end
          end
          WAIT_ICW3: begin
            if (ev_a0) begin
              stb_nxt[STB_ICW3] = 1'b1;
              state_nxt         = ic4 ? WAIT_ICW4 : READY;
            end
          end
          WAIT_ICW4: begin
            if (ev_a0) begin
              stb_nxt[STB_ICW4] = 1'b1;
              state_nxt         = READY;
            end
          end
          READY: begin
            if (ev_a0)                      stb_nxt[STB_OCW1] = 1'b1;
            else if (ev_data[OCW3_SEL_BIT]) stb_nxt[STB_OCW3] = 1'b1;
            else                            stb_nxt[STB_OCW2] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stb_q        <= '0;
      internal_bus <= '0;
      init_done    <= 1'b0;
      ltim         <= 1'b0;
      single_mode  <= 1'b0;
      ic4          <= 1'b0;
      vector_base  <= '0;
      cascade_cfg  <= '0;
      auto_eoi     <= 1'b0;
      upm          <= 1'b0;
    end else begin
      stb_q <= stb_nxt;
      if (|stb_nxt) begin
        internal_bus <= ev_data;
      end
      if (stb_nxt[STB_ICW1]) begin
        ltim        <= ev_data[LTIM_BIT];
        single_mode <= ev_data[SNGL_BIT];
        ic4         <= ev_data[IC4_BIT];
        auto_eoi    <= 1'b0;
        upm         <= 1'b0;
        init_done   <= 1'b0;
      end
      if (stb_nxt[STB_ICW2]) begin
        vector_base <= ev_data[7:3];
      end
      if (stb_nxt[STB_ICW3]) begin
        cascade_cfg <= ev_data;
      end
      if (stb_nxt[STB_ICW4]) begin
        auto_eoi <= ev_data[1];
        upm      <= ev_data[0];
      end
      if ((stb_nxt[STB_ICW2] || stb_nxt[STB_ICW3] || stb_nxt[STB_ICW4]) &&
          (state_nxt == READY)) begin
        init_done <= 1'b1;
      end
    end
  end

`ifdef PIC_WR_ERR_EN
  // Every accepted write produces exactly one strobe, so an event with no
  // strobe is an ignored write.
  logic ignored;
  assign ignored = wr_event && (stb_nxt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else if (stb_nxt[STB_ICW1]) begin
      wr_err <= 1'b0;
    end else if (ignored) begin
      wr_err <= 1'b1;
    end
  end
`endif

  assign icw1_write = stb_q[STB_ICW1];
  assign icw2_write = stb_q[STB_ICW2];
  assign icw3_write = stb_q[STB_ICW3];
  assign icw4_write = stb_q[STB_ICW4];
  assign ocw1_write = stb_q[STB_OCW1];
  assign ocw2_write = stb_q[STB_OCW2];
  assign ocw3_write = stb_q[STB_OCW3];

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Self-checking bench for pic_cmd_sequencer: directed sequences from the
// command protocol plus randomized writes, compared against a behavioural
// model of the 8259A initialization/command rules.
module tb_pic_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       a0 = 1'b0;
  logic [7:0] data_bus = 8'h00;
  logic [7:0] internal_bus;
  logic       icw1_write, icw2_write, icw3_write, icw4_write;
  logic       ocw1_write, ocw2_write, ocw3_write;
  logic       init_done, ltim, single_mode, auto_eoi, upm;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg;
`ifdef PIC_WR_ERR_EN
  logic       wr_err;
`endif

  pic_cmd_sequencer #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs_n         (cs_n),
    .wr_n         (wr_n),
    .a0           (a0),
    .data_bus     (data_bus),
    .internal_bus (internal_bus),
    .icw1_write   (icw1_write),
    .icw2_write   (icw2_write),
    .icw3_write   (icw3_write),
    .icw4_write   (icw4_write),
    .ocw1_write   (ocw1_write),
    .ocw2_write   (ocw2_write),
    .ocw3_write   (ocw3_write),
    .init_done    (init_done),
    .ltim         (ltim),
    .single_mode  (single_mode),
    .vector_base  (vector_base),
    .cascade_cfg  (cascade_cfg),
    .auto_eoi     (auto_eoi),
    .upm          (upm)
`ifdef PIC_WR_ERR_EN
    ,
    .wr_err       (wr_err)
`endif
  );

  always #5 clk = ~clk;

  // strobe index: 0 icw1, 1 icw2, 2 icw3, 3 icw4, 4 ocw1, 5 ocw2, 6 ocw3
  wire [6:0] stb = {ocw3_write, ocw2_write, ocw1_write, icw4_write,
                    icw3_write, icw2_write, icw1_write};

  int errors = 0;
  int checks = 0;
  logic quiet = 1'b0;

  // Behavioural model. m_expect names the next ICW the sequence wants
  // (2, 3 or 4), 0 before any ICW1, 5 once initialization is complete.
  int         m_expect;
  logic [7:0] m_bus, m_casc;
  logic [4:0] m_vb;
  logic       m_ltim, m_sngl, m_ic4, m_aeoi, m_upm, m_done, m_err;

  task automatic model_reset();
    m_expect = 0; m_bus = 0; m_casc = 0; m_vb = 0;
    m_ltim = 0; m_sngl = 0; m_ic4 = 0; m_aeoi = 0; m_upm = 0; m_done = 0; m_err = 0;
  endtask

  // Returns the index of the strobe the write must produce, -1 if ignored.
  task automatic model_write(input bit wa0, input logic [7:0] d, output int want);
    want = -1;
    if (!wa0 && d[4]) begin
      want = 0;
      m_ltim = d[3]; m_sngl = d[1]; m_ic4 = d[0];
      m_aeoi = 0; m_upm = 0; m_done = 0; m_err = 0;
      m_expect = 2;
    end else if (m_expect == 5) begin
      want = wa0 ? 4 : (d[3] ? 6 : 5);
    end else if (m_expect == 0 || !wa0) begin
      m_err = 1;
    end else begin
      want = m_expect - 1;
      if (m_expect == 2) m_vb = d[7:3];
      if (m_expect == 3) m_casc = d;
      if (m_expect == 4) begin m_aeoi = d[1]; m_upm = d[0]; end
      // which ICW comes next: ICW3 only in cascade mode, ICW4 only if requested
      if (m_expect == 2 && !m_sngl) m_expect = 3;
      else if (m_expect < 4 && m_ic4) m_expect = 4;
      else m_expect = 5;
      if (m_expect == 5) m_done = 1;
    end
    if (want >= 0) m_bus = d;
  endtask

  // Between transactions every output must match the model and no strobe may fire.
  always @(negedge clk) begin
    if (quiet) begin
      checks++;
      if ({internal_bus, init_done, ltim, single_mode, vector_base, cascade_cfg,
           auto_eoi, upm, stb} !==
          {m_bus, m_done, m_ltim, m_sngl, m_vb, m_casc, m_aeoi, m_upm, 7'b0}) begin
        errors++;
        $display("FAIL steady t=%0t: bus=%h done=%b ltim=%b sngl=%b vb=%h casc=%h aeoi=%b upm=%b stb=%b, want bus=%h done=%b ltim=%b sngl=%b vb=%h casc=%h aeoi=%b upm=%b stb=0",
                 $time, internal_bus, init_done, ltim, single_mode, vector_base, cascade_cfg,
                 auto_eoi, upm, stb, m_bus, m_done, m_ltim, m_sngl, m_vb, m_casc, m_aeoi, m_upm);
      end
`ifdef PIC_WR_ERR_EN
      checks++;
      if (wr_err !== m_err) begin
        errors++;
        $display("FAIL wr_err t=%0t: got %b want %b", $time, wr_err, m_err);
      end
`endif
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic apply_reset();
    quiet = 1'b0;
    @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    quiet = 1'b1;
  endtask

  // One CPU write; watches a bounded window after wr_n rises for the strobe.
  task automatic do_write(input bit wa0, input logic [7:0] d, input string tag);
    int want, hits;
    logic [6:0] seen;
    logic [7:0] bus_at;
    quiet = 1'b0;
    model_write(wa0, d, want);
    @(negedge clk);
    a0 = wa0; data_bus = d; cs_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b0;
    repeat (1 + $urandom_range(1, 3)) @(negedge clk);
    wr_n = 1'b1;
    hits = 0; seen = '0; bus_at = '0;
    repeat (8) begin
      @(negedge clk);
      if (stb != 7'b0) begin
        hits++; seen = stb; bus_at = internal_bus;
      end
    end
    cs_n = 1'b1;
    checks++;
    if (want < 0 ? (hits != 0)
                 : (hits != 1 || seen != (7'b1 << want) || bus_at != d)) begin
      errors++;
      $display("FAIL write %s a0=%b d=%h: strobe cycles=%0d strobes=%b bus=%h, want cycles=%0d strobe idx=%0d bus=%h",
               tag, wa0, d, hits, seen, bus_at, (want < 0) ? 0 : 1, want, d);
    end
    @(negedge clk);
    quiet = 1'b1;
  endtask

  initial begin : stim
    int hits;
    bit ra0;
    logic [7:0] rd;
    model_reset();
    apply_reset();
    check_val("reset_init_done", init_done, 0);
    check_val("reset_bus", internal_bus, 0);

    // single mode with ICW4
    do_write(0, 8'h13, "icw1_single");
    do_write(1, 8'h20, "icw2");
    do_write(1, 8'h01, "icw4");
    check_val("t1_vector_base", vector_base, 5'h04);
    check_val("t1_upm", upm, 1);
    check_val("t1_single", single_mode, 1);
    check_val("t1_init_done", init_done, 1);
    check_val("t1_model_vb", m_vb, 5'h04);

    // cascade mode
    apply_reset();
    do_write(0, 8'h11, "icw1_cascade");
    do_write(1, 8'h08, "icw2");
    do_write(1, 8'h04, "icw3");
    do_write(1, 8'h03, "icw4");
    check_val("t2_cascade", cascade_cfg, 8'h04);
    check_val("t2_auto_eoi", auto_eoi, 1);
    check_val("t2_upm", upm, 1);
    check_val("t2_init_done", init_done, 1);

    // operational commands
    do_write(1, 8'hFB, "ocw1");
    check_val("t3_ocw1_bus", internal_bus, 8'hFB);
    do_write(0, 8'h20, "ocw2");
    do_write(0, 8'h0B, "ocw3");
    check_val("t3_ocw3_bus", internal_bus, 8'h0B);

    // ICW1 in the middle of a sequence restarts it
    do_write(0, 8'h11, "icw1_a");
    do_write(1, 8'h08, "icw2_a");
    do_write(0, 8'h13, "icw1_restart");
    check_val("t4_init_done", init_done, 0);
    check_val("t4_auto_eoi", auto_eoi, 0);
    check_val("t4_cascade_kept", cascade_cfg, 8'h04);
    do_write(1, 8'h30, "icw2_after_restart");
    check_val("t4_vector_base", vector_base, 5'h06);

    // writes before initialization are ignored
    apply_reset();
    do_write(1, 8'h55, "pre_init_a0_1");
    do_write(0, 8'h08, "pre_init_ocw");
    check_val("t5_bus_unchanged", internal_bus, 8'h00);
`ifdef PIC_WR_ERR_EN
    check_val("t5_wr_err_set", wr_err, 1);
    do_write(0, 8'h13, "icw1_clears_err");
    check_val("t5_wr_err_clr", wr_err, 0);
`endif

    // reset asserted while wr_n is low; the rising edge after release is dropped
    quiet = 1'b0;
    @(negedge clk);
    a0 = 1'b0; data_bus = 8'h13; cs_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (stb != 7'b0) hits++;
    end
    cs_n = 1'b1;
    check_val("t6_no_strobe", hits, 0);
    @(negedge clk);
    quiet = 1'b1;
    @(negedge clk);
    check_val("t6_init_done", init_done, 0);
    check_val("t6_bus", internal_bus, 0);

    // randomized traffic
    apply_reset();
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 59) == 0) apply_reset();
      if ($urandom_range(0, 9) < 2) begin
        ra0 = 1'b0;
        rd = 8'($urandom) | 8'h10;
      end else begin
        ra0 = 1'($urandom_range(0, 1));
        rd = 8'($urandom);
      end
      do_write(ra0, rd, "random");
    end

    repeat (3) @(negedge clk);
    quiet = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on run time in case a wait never returns.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

endmodule
